// File: rtl/div_arb_pkg.sv
// div_arb_pkg: state encoding and default sizing shared by the divider request arbiter.
package div_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
endpackage

// File: rtl/divider_request_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant, search starts at ptr_i.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] j;
  // Walk offsets from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/divider_request_arbiter.sv
// divider_request_arbiter: shares one divider among NUM_REQ requesters, one op in flight.
// DIV_ZERO_BYPASS_EN: answer divisor-0 requests directly (all-ones quotient, dbz set).
module divider_request_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic                       div_done,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic [WIDTH-1:0]           rsp_remainder,
  output logic                       rsp_dbz
);
  localparam int IDW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gnt_idx;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0] lane_dvd, lane_dvs;
  logic [NUM_REQ-1:0] gnt;
  logic any_req;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_req)
  );
  assign lane_dvd = req_dividend[gnt_idx*WIDTH +: WIDTH];
  assign lane_dvs = req_divisor[gnt_idx*WIDTH +: WIDTH];
`ifdef DIV_ZERO_BYPASS_EN
  logic dbz_q, dbz_d;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
`ifdef DIV_ZERO_BYPASS_EN
    dbz_d = dbz_q;
`endif
    case (state_q)
      IDLE: if (any_req) begin
        id_d = gnt_idx;
        dvd_d = lane_dvd;
        dvs_d = lane_dvs;
        state_d = ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
        dbz_d = 1'b0;
        if (lane_dvs == '0) begin
          state_d = RESP;
          quo_d = '1;
          rem_d = lane_dvd;
          dbz_d = 1'b1;
        end
`endif
      end
      ISSUE: state_d = WAIT;
      WAIT: if (div_done) begin
        quo_d = div_quotient;
        rem_d = div_remainder;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        ptr_d = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      dbz_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
`ifdef DIV_ZERO_BYPASS_EN
      dbz_q <= dbz_d;
`endif
    end
  end
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign div_start = state_q == ISSUE;
  assign div_dividend = dvd_q;
  assign div_divisor = dvs_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_quotient = quo_q;
  assign rsp_remainder = rem_q;
`ifdef DIV_ZERO_BYPASS_EN
  assign rsp_dbz = dbz_q;
`else
  assign rsp_dbz = 1'b0;
`endif
endmodule

// File: tb/tb_divider_request_arbiter.sv
// tb_divider_request_arbiter: directed table, corner sequences and random traffic vs a reference model.
module tb_divider_request_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic div_start, div_done, rsp_valid, rsp_ready, rsp_dbz;
  logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder, rsp_quotient, rsp_remainder;
  logic [1:0] rsp_id;
  int checks = 0;
  int failures = 0;
  int ptr_m = 0;
  typedef struct {
    logic [N-1:0] v;
    logic [W-1:0] dd, dv;
    int id;
    logic [W-1:0] q, r;
    int lat, bp;
  } vec_t;
  vec_t tbl[9];
  always #5 clk = ~clk;
  divider_request_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .req_ready(req_ready), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  // Starts at a negedge in IDLE; plays the requester, the divider and the response consumer.
  task automatic run_txn(input logic [N-1:0] v, input logic [N*W-1:0] dds, input logic [N*W-1:0] dvs,
                         input int id, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int lat, input int bp);
    logic [W-1:0] dd, dv;
    logic byp;
    dd = dds[id*W +: W];
    dv = dvs[id*W +: W];
`ifdef DIV_ZERO_BYPASS_EN
    byp = (dv == '0);
`else
    byp = 1'b0;
`endif
    req_valid = v;
    req_dividend = dds;
    req_divisor = dvs;
    #1;
    chk("req_ready_grant", {28'd0, req_ready}, 32'd1 << id);
    @(negedge clk);
    req_valid = v & ~(N'(1) << id);
    #1;
    chk("req_ready_busy", {28'd0, req_ready}, 0);
    if (byp) begin
      chk("div_start_bypass", {31'd0, div_start}, 0);
      chk("rsp_valid_bypass", {31'd0, rsp_valid}, 1);
    end else begin
      chk("div_start", {31'd0, div_start}, 1);
      chk("div_dividend", {24'd0, div_dividend}, {24'd0, dd});
      chk("div_divisor", {24'd0, div_divisor}, {24'd0, dv});
      @(negedge clk);
      chk("div_start_once", {31'd0, div_start}, 0);
      for (int c = 0; c < lat; c++) begin
        chk("rsp_valid_wait", {31'd0, rsp_valid}, 0);
        chk("operand_hold", {24'd0, div_dividend}, {24'd0, dd});
        @(negedge clk);
      end
      div_done = 1'b1;
      div_quotient = (dv == '0) ? '1 : dd / dv;
      div_remainder = (dv == '0) ? dd : dd % dv;
      @(negedge clk);
      div_done = 1'b0;
      div_quotient = W'($urandom);
      div_remainder = W'($urandom);
      chk("rsp_valid", {31'd0, rsp_valid}, 1);
    end
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("bp_quotient", {24'd0, rsp_quotient}, {24'd0, eq});
      chk("bp_req_ready", {28'd0, req_ready}, 0);
    end
    chk("rsp_id", {30'd0, rsp_id}, id);
    chk("rsp_quotient", {24'd0, rsp_quotient}, {24'd0, eq});
    chk("rsp_remainder", {24'd0, rsp_remainder}, {24'd0, er});
    chk("rsp_dbz", {31'd0, rsp_dbz}, {31'd0, byp});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after", {31'd0, rsp_valid}, 0);
    ptr_m = (id + 1) % N;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, {28'd0, req_ready}, 0);
    chk({tag, "_div_start"}, {31'd0, div_start}, 0);
    chk({tag, "_div_operands"}, {16'd0, div_dividend, div_divisor}, 0);
    chk({tag, "_rsp"}, {13'd0, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz}, 0);
  endtask
  initial begin
    logic [N*W-1:0] dds, dvs;
    logic [N-1:0] v;
    logic [W-1:0] dd, dv;
    int id;
    tbl[0] = '{4'b0001, 8'd100, 8'd7,   0, 8'd14,  8'd2,  2, 0};
    tbl[1] = '{4'b1000, 8'd99,  8'd10,  3, 8'd9,   8'd9,  0, 0};
    tbl[2] = '{4'b1111, 8'd200, 8'd9,   0, 8'd22,  8'd2,  1, 5};
    tbl[3] = '{4'b1111, 8'd255, 8'd1,   1, 8'd255, 8'd0,  0, 0};
    tbl[4] = '{4'b1111, 8'd7,   8'd200, 2, 8'd0,   8'd7,  3, 1};
    tbl[5] = '{4'b1111, 8'd81,  8'd4,   3, 8'd20,  8'd1,  0, 0};
    tbl[6] = '{4'b0100, 8'd50,  8'd5,   2, 8'd10,  8'd0,  1, 0};
    tbl[7] = '{4'b0011, 8'd64,  8'd3,   0, 8'd21,  8'd1,  0, 0};
    tbl[8] = '{4'b0010, 8'd45,  8'd0,   1, 8'hFF,  8'd45, 1, 2};
    rst = 1'b1;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    div_done = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    foreach (tbl[i]) begin
      dds = {N{8'hA5}};
      dvs = {N{8'h03}};
      dds[tbl[i].id*W +: W] = tbl[i].dd;
      dvs[tbl[i].id*W +: W] = tbl[i].dv;
      run_txn(tbl[i].v, dds, dvs, tbl[i].id, tbl[i].q, tbl[i].r, tbl[i].lat, tbl[i].bp);
    end
    // Stray completion while idle must not produce a response.
    req_valid = '0;
    div_done = 1'b1;
    div_quotient = 8'd77;
    @(negedge clk);
    div_done = 1'b0;
    chk("stray_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("stray_div_start", {31'd0, div_start}, 0);
    @(negedge clk);
    chk("stray_rsp_valid2", {31'd0, rsp_valid}, 0);
    dds = {N{8'd30}};
    dvs = {N{8'd4}};
    run_txn(4'b1111, dds, dvs, ptr_m, 8'd7, 8'd2, 0, 0);
    // Reset while waiting on the divider; the late completion is dropped.
    req_valid = 4'b0100;
    req_dividend = {N{8'd100}};
    req_divisor = {N{8'd7}};
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midwait_reset");
    @(negedge clk);
    rst = 1'b0;
    div_done = 1'b1;
    div_quotient = 8'd55;
    div_remainder = 8'd5;
    @(negedge clk);
    div_done = 1'b0;
    chk("postreset_rsp_valid", {31'd0, rsp_valid}, 0);
    @(negedge clk);
    chk_all_zero("postreset_idle");
    ptr_m = 0;
    run_txn(4'b1111, {N{8'd9}}, {N{8'd2}}, 0, 8'd4, 8'd1, 0, 0);
    for (int t = 0; t < 60; t++) begin
      v = N'($urandom_range(1, 15));
      dds = {$urandom};
      for (int l = 0; l < N; l++)
        dvs[l*W +: W] = ($urandom_range(0, 3) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      id = winner(v, ptr_m);
      dd = dds[id*W +: W];
      dv = dvs[id*W +: W];
      run_txn(v, dds, dvs, id, (dv == 0) ? 8'hFF : dd / dv, (dv == 0) ? dd : dd % dv,
              $urandom_range(0, 3), $urandom_range(0, 2));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/divider_request_arbiter.md
DIVIDER_REQUEST_ARBITER -- requirements
Module: divider_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one divider, range 2..8.
REQ-002 SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ: one request line per requester.
REQ-006 SHALL have port req_dividend, input, NUM_REQ*WIDTH: requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_divisor, input, NUM_REQ*WIDTH: packed per requester, same layout as req_dividend.
REQ-008 SHALL have port req_ready, output, NUM_REQ: one-hot accept strobe.
REQ-009 SHALL have port div_start, output, 1: one-cycle start pulse to the divider.
REQ-010 SHALL have port div_dividend, output, WIDTH; port div_divisor, output, WIDTH: registered operands to the divider.
REQ-011 SHALL have port div_done, input, 1: completion pulse from the divider.
REQ-012 SHALL have port div_quotient, input, WIDTH; port div_remainder, input, WIDTH: divider results, valid while div_done=1.
REQ-013 SHALL have port rsp_valid, output, 1: response valid.
REQ-014 SHALL have port rsp_ready, input, 1: response consumer accept.
REQ-015 SHALL have port rsp_id, output, $clog2(NUM_REQ): index of the requester being answered.
REQ-016 SHALL have port rsp_quotient, output, WIDTH; port rsp_remainder, output, WIDTH; port rsp_dbz, output, 1: divide-by-zero flag.

Function
REQ-017 SHALL implement an FSM with states IDLE, ISSUE, WAIT, RESP and one outstanding operation at most.
REQ-018 In IDLE with any req_valid bit set: round-robin grant, starting search at pointer ptr; req_ready[winner]=1 combinationally in that cycle; operands and id registered at the edge; next state ISSUE.
REQ-019 In ISSUE: div_start=1 for exactly one cycle; next state WAIT.
REQ-020 In WAIT: hold div_dividend/div_divisor stable; on div_done=1 register quotient and remainder; next state RESP.
REQ-021 In RESP: rsp_valid=1 with stable rsp_* until rsp_ready=1; on handshake set ptr=(winner+1) mod NUM_REQ; next state IDLE.
REQ-022 SHALL have minimum latency accept-to-rsp_valid of 3 cycles plus divider time, i.e. rsp_valid in the cycle after div_done.
REQ-023 req_ready SHALL be 0 in every state except IDLE; requests arriving in other states wait.
REQ-024 Simultaneous requests SHALL be granted round-robin; no requester waits more than NUM_REQ-1 grants.
REQ-025 div_done outside WAIT SHALL be ignored.
REQ-026 A requester that drops req_valid before it is granted SHALL simply not be granted; nothing is recorded.

Reset
REQ-027 rst SHALL force IDLE, ptr=0, and all outputs and operand/result registers to 0, at any point including mid-WAIT; a later div_done SHALL be ignored.

Configuration
REQ-028 Macro DIV_ZERO_BYPASS_EN defined: a granted divisor of 0 goes directly to RESP without div_start, with rsp_quotient all ones, rsp_remainder=dividend, rsp_dbz=1.
REQ-029 Macro DIV_ZERO_BYPASS_EN undefined: divisor 0 is issued to the divider like any other; rsp_dbz is tied 0.

Structure
REQ-030 Package div_arb_pkg SHALL hold the state encoding (2-bit enum) and the default NUM_REQ/WIDTH constants.
REQ-031 Sub-module rr_arbiter SHALL compute the one-hot grant from req_valid and ptr combinationally.

Verification
REQ-032 Single request: req_valid=0001, 100/7 -> req_ready=0001, one div_start pulse, rsp_id=0, quotient 14, remainder 2.
REQ-033 All four request together, ptr=0 -> grants in order 0,1,2,3; then a second round with requester 2 only -> grant 2.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held; no new req_ready until the handshake.
REQ-035 Divisor 0, dividend 45 -> with macro: no div_start, quotient 0xFF, remainder 45, rsp_dbz=1; without macro: div_start issued, rsp_dbz=0.
REQ-036 rst asserted in WAIT, then div_done pulsed -> state IDLE, all outputs 0, no rsp_valid.
REQ-037 Stray div_done in IDLE -> no state change; rsp_valid stays 0.
